// File: rtl/id_issue_queue_pkg.sv
// Shared types for the ID/issue decoupling queue: the decoded entry carried
// from the decoder lanes to issue, plus small width helpers.
package id_issue_queue_pkg;

  typedef logic [15:0] sbe_t;

  typedef struct packed {
    sbe_t        sbe;
    logic [31:0] orig_instr;
    logic        is_ctrl_flow;
  } id_entry_t;

  // A one-entry buffer still needs a 1-bit pointer to declare.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 32'd1) ? $clog2(depth) : 32'd1;
  endfunction

endpackage

// File: rtl/id_issue_queue_if.sv
// Decode-side and issue-side handshake bundle of the ID/issue queue.
// The master drives decode lanes, acks and flush; the slave is the queue.
interface id_issue_queue_if
  import id_issue_queue_pkg::*;
#(
  parameter int unsigned NrInPorts  = 2,
  parameter int unsigned NrOutPorts = 2,
  parameter int unsigned Depth      = 4
);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic                             flush_i;
  logic      [NrInPorts-1:0]        decode_valid_i;
  id_entry_t [NrInPorts-1:0]        decode_entry_i;
  logic      [NrInPorts-1:0]        decode_ready_o;
  logic      [NrOutPorts-1:0]       issue_valid_o;
  id_entry_t [NrOutPorts-1:0]       issue_entry_o;
  logic      [NrOutPorts-1:0]       issue_ack_i;
  logic      [CntW-1:0]             occupancy_o;

  modport master (
    output flush_i, decode_valid_i, decode_entry_i, issue_ack_i,
    input  decode_ready_o, issue_valid_o, issue_entry_o, occupancy_o
  );

  modport slave (
    input  flush_i, decode_valid_i, decode_entry_i, issue_ack_i,
    output decode_ready_o, issue_valid_o, issue_entry_o, occupancy_o
  );

endinterface

// File: rtl/id_issue_queue_checker.sv
// Protocol checks for the ID/issue queue: lane prefixes, acks only on
// valid lanes, and occupancy never exceeding the buffer depth.
module id_issue_queue_checker #(
  parameter int unsigned NrOutPorts = 2,
  parameter int unsigned Depth      = 4,
  parameter int unsigned CntW       = 3
) (
  input logic                  clk_i,
  input logic                  rst_i,
  input logic                  valid_prefix_ok_i,
  input logic                  ack_prefix_ok_i,
  input logic [NrOutPorts-1:0] issue_ack_i,
  input logic [NrOutPorts-1:0] issue_valid_i,
  input logic [CntW-1:0]       count_i
);

  // Sampled once per cycle outside reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (valid_prefix_ok_i);
      assert (ack_prefix_ok_i);
      assert ((issue_ack_i & ~issue_valid_i) == '0);
      assert (int'(count_i) <= int'(Depth));
    end
  end

endmodule

// File: rtl/id_issue_queue_lane_popcount.sv
// Counts accepted decode lanes and acked issue lanes, and reports whether
// the valid/ack vectors form contiguous prefixes starting at lane 0.
module id_lane_popcount #(
  parameter int unsigned NrInPorts  = 2,
  parameter int unsigned NrOutPorts = 2,
  parameter int unsigned CntW       = 3
) (
  input  logic [NrInPorts-1:0]  decode_valid_i,
  input  logic [NrInPorts-1:0]  decode_ready_i,
  input  logic [NrOutPorts-1:0] issue_ack_i,
  output logic [CntW-1:0]       n_push_o,
  output logic [CntW-1:0]       n_pop_o,
  output logic                  valid_prefix_ok_o,
  output logic                  ack_prefix_ok_o
);

  // Decode-side count and prefix check.
  always_comb begin
    n_push_o          = '0;
    valid_prefix_ok_o = 1'b1;
    for (int i = 0; i < int'(NrInPorts); i++) begin
      n_push_o = n_push_o + CntW'(decode_ready_i[i]);
      if (i > 0) begin
        valid_prefix_ok_o = valid_prefix_ok_o & ~(decode_valid_i[i] & ~decode_valid_i[i-1]);
      end else begin
        valid_prefix_ok_o = valid_prefix_ok_o;
      end
    end
  end

  // Issue-side count and prefix check.
  always_comb begin
    n_pop_o         = '0;
    ack_prefix_ok_o = 1'b1;
    for (int j = 0; j < int'(NrOutPorts); j++) begin
      n_pop_o = n_pop_o + CntW'(issue_ack_i[j]);
      if (j > 0) begin
        ack_prefix_ok_o = ack_prefix_ok_o & ~(issue_ack_i[j] & ~issue_ack_i[j-1]);
      end else begin
        ack_prefix_ok_o = ack_prefix_ok_o;
      end
    end
  end

endmodule

// File: rtl/id_issue_queue.sv
// Multi-lane ID/issue decoupling queue: a Depth-entry circular buffer with
// in-order multi-lane push and pop; acks free space for same-cycle pushes.
module id_issue_queue
  import id_issue_queue_pkg::*;
#(
  parameter int unsigned NrInPorts  = 2,
  parameter int unsigned NrOutPorts = 2,
  parameter int unsigned Depth      = 4
) (
  input logic             clk_i,
  input logic             rst_i,
  id_issue_queue_if.slave bus_io
);

  localparam int unsigned PtrW = ptr_width(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [CntW-1:0]       n_push, n_pop;
  logic                  valid_prefix_ok, ack_prefix_ok;
  logic [NrInPorts-1:0]  ready;
  logic [PtrW-1:0]       wr_idx [NrInPorts];
  int                    free;
  id_entry_t             mem_q [Depth];

  id_lane_popcount #(
    .NrInPorts (NrInPorts),
    .NrOutPorts(NrOutPorts),
    .CntW      (CntW)
  ) u_popcount (
    .decode_valid_i   (bus_io.decode_valid_i),
    .decode_ready_i   (ready),
    .issue_ack_i      (bus_io.issue_ack_i),
    .n_push_o         (n_push),
    .n_pop_o          (n_pop),
    .valid_prefix_ok_o(valid_prefix_ok),
    .ack_prefix_ok_o  (ack_prefix_ok)
  );

  // Acks retired this cycle count as free space for this cycle's pushes.
  always_comb begin
    free = int'(Depth) - int'(count_q) + int'(n_pop);
    for (int i = 0; i < int'(NrInPorts); i++) begin
      ready[i]  = bus_io.decode_valid_i[i] && (i < free) && !bus_io.flush_i && !rst_i;
      wr_idx[i] = PtrW'((int'(wr_ptr_q) + i) % int'(Depth));
    end
  end

  assign bus_io.decode_ready_o = ready;

  // Issue lanes read straight from state; no bypass of this cycle's writes.
  always_comb begin
    for (int j = 0; j < int'(NrOutPorts); j++) begin
      bus_io.issue_valid_o[j] = int'(count_q) > j;
      bus_io.issue_entry_o[j] = mem_q[PtrW'((int'(rd_ptr_q) + j) % int'(Depth))];
    end
  end

  assign bus_io.occupancy_o = count_q;

  // Next-state pointer and count arithmetic.
  always_comb begin
    wr_ptr_d = PtrW'((int'(wr_ptr_q) + int'(n_push)) % int'(Depth));
    rd_ptr_d = PtrW'((int'(rd_ptr_q) + int'(n_pop)) % int'(Depth));
    count_d  = CntW'(int'(count_q) + int'(n_push) - int'(n_pop));
  end

  // Control state; flush and reset both empty the queue.
  always_ff @(posedge clk_i) begin
    if (rst_i || bus_io.flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; ready already excludes reset and flush cycles.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(NrInPorts); i++) begin
      if (ready[i]) begin
        mem_q[wr_idx[i]] <= bus_io.decode_entry_i[i];
      end
    end
  end

  id_issue_queue_checker #(
    .NrOutPorts(NrOutPorts),
    .Depth     (Depth),
    .CntW      (CntW)
  ) u_checker (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .valid_prefix_ok_i(valid_prefix_ok),
    .ack_prefix_ok_i  (ack_prefix_ok),
    .issue_ack_i      (bus_io.issue_ack_i),
    .issue_valid_i    (bus_io.issue_valid_o),
    .count_i          (count_q)
  );

endmodule

// File: tb/tb_id_issue_queue.sv
// Directed bench for id_issue_queue: a 4-entry dual-lane instance and a
// single-entry single-lane instance, with hand-computed expectations.
module tb_id_issue_queue;
  import id_issue_queue_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  id_issue_queue_if #(.NrInPorts(2), .NrOutPorts(2), .Depth(4)) bus ();
  id_issue_queue_if #(.NrInPorts(1), .NrOutPorts(1), .Depth(1)) bus1 ();

  id_issue_queue #(.NrInPorts(2), .NrOutPorts(2), .Depth(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_io(bus)
  );

  id_issue_queue #(.NrInPorts(1), .NrOutPorts(1), .Depth(1)) dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus_io(bus1)
  );

  function automatic id_entry_t mk(input int v);
    id_entry_t e;
    e.sbe          = 16'(v);
    e.orig_instr   = 32'hA500_0000 | 32'(v);
    e.is_ctrl_flow = v[0];
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] valid, input int e0, input int e1,
                       input logic [1:0] ack, input logic flush);
    bus.decode_valid_i    = valid;
    bus.decode_entry_i[0] = mk(e0);
    bus.decode_entry_i[1] = mk(e1);
    bus.issue_ack_i       = ack;
    bus.flush_i           = flush;
  endtask

  task automatic drive1(input logic valid, input int e0, input logic ack);
    bus1.decode_valid_i    = valid;
    bus1.decode_entry_i[0] = mk(e0);
    bus1.issue_ack_i       = ack;
    bus1.flush_i           = 1'b0;
  endtask

  initial begin
    // Reset held for two edges with both lanes requesting.
    rst = 1'b1;
    drive(2'b11, 1, 2, 2'b00, 1'b0);
    drive1(1'b1, 1, 1'b0);
    #2;
    chk("rst_ready_c0", bus.decode_ready_o, 2'b00);
    chk("rst_ready1_c0", bus1.decode_ready_o, 1'b0);
    tick();
    chk("rst_ready_c1", bus.decode_ready_o, 2'b00);
    tick();
    rst = 1'b0;
    drive(2'b00, 0, 0, 2'b00, 1'b0);
    drive1(1'b0, 0, 1'b0);
    #1;
    chk("rst_ivalid", bus.issue_valid_o, 2'b00);
    chk("rst_occ", bus.occupancy_o, 3'd0);
    chk("rst_occ1", bus1.occupancy_o, 1'd0);

    // Fill: A,B then C,D, then full.
    tick();
    drive(2'b11, 1, 2, 2'b00, 1'b0);
    #2;
    chk("fill_ready_ab", bus.decode_ready_o, 2'b11);
    tick();
    chk("fill_occ2", bus.occupancy_o, 3'd2);
    chk("fill_ivalid", bus.issue_valid_o, 2'b11);
    drive(2'b11, 3, 4, 2'b00, 1'b0);
    #2;
    chk("fill_ready_cd", bus.decode_ready_o, 2'b11);
    tick();
    chk("fill_occ4", bus.occupancy_o, 3'd4);
    drive(2'b11, 5, 6, 2'b00, 1'b0);
    #2;
    chk("full_ready", bus.decode_ready_o, 2'b00);
    chk("full_e0_A", bus.issue_entry_o[0], mk(1));
    chk("full_e1_B", bus.issue_entry_o[1], mk(2));
    tick();
    chk("full_occ_hold", bus.occupancy_o, 3'd4);

    // Full with one ack: only lane 0 may push.
    drive(2'b11, 5, 6, 2'b01, 1'b0);
    #2;
    chk("fullack_ready", bus.decode_ready_o, 2'b01);
    tick();
    chk("fullack_e0_B", bus.issue_entry_o[0], mk(2));
    chk("fullack_e1_C", bus.issue_entry_o[1], mk(3));
    chk("fullack_occ", bus.occupancy_o, 3'd4);

    // Drain B,C then D,E.
    drive(2'b00, 0, 0, 2'b11, 1'b0);
    tick();
    chk("drain_e0_D", bus.issue_entry_o[0], mk(4));
    chk("drain_e1_E", bus.issue_entry_o[1], mk(5));
    chk("drain_occ2", bus.occupancy_o, 3'd2);
    tick();
    chk("drain_occ0", bus.occupancy_o, 3'd0);
    chk("drain_ivalid", bus.issue_valid_o, 2'b00);

    // Stream 10 entries with 2 acks per cycle across the pointer wrap.
    for (int k = 0; k < 6; k++) begin
      drive((k < 5) ? 2'b11 : 2'b00, 100 + 2 * k, 101 + 2 * k,
            (k > 0) ? 2'b11 : 2'b00, 1'b0);
      #2;
      if (k < 5) chk("stream_ready", bus.decode_ready_o, 2'b11);
      if (k > 0) begin
        chk("stream_e0", bus.issue_entry_o[0], mk(100 + 2 * (k - 1)));
        chk("stream_e1", bus.issue_entry_o[1], mk(101 + 2 * (k - 1)));
      end
      tick();
    end
    chk("stream_occ_end", bus.occupancy_o, 3'd0);

    // Flush with three entries held, acks and pushes all ignored.
    drive(2'b11, 200, 201, 2'b00, 1'b0);
    tick();
    drive(2'b01, 202, 0, 2'b00, 1'b0);
    #2;
    chk("flush_pre_ready", bus.decode_ready_o, 2'b01);
    tick();
    chk("flush_pre_occ", bus.occupancy_o, 3'd3);
    drive(2'b11, 203, 204, 2'b11, 1'b1);
    #2;
    chk("flush_ready", bus.decode_ready_o, 2'b00);
    tick();
    chk("flush_occ", bus.occupancy_o, 3'd0);
    chk("flush_ivalid", bus.issue_valid_o, 2'b00);
    drive(2'b01, 210, 0, 2'b00, 1'b0);
    #2;
    chk("postflush_ready", bus.decode_ready_o, 2'b01);
    chk("postflush_nobypass", bus.issue_valid_o, 2'b00);
    tick();
    chk("postflush_ivalid", bus.issue_valid_o, 2'b01);
    chk("postflush_e0", bus.issue_entry_o[0], mk(210));
    chk("postflush_occ", bus.occupancy_o, 3'd1);
    drive(2'b00, 0, 0, 2'b00, 1'b0);

    // Single-lane, single-entry: one entry per cycle with ack.
    drive1(1'b1, 300, 1'b0);
    #2;
    chk("single_ready0", bus1.decode_ready_o, 1'b1);
    tick();
    chk("single_valid0", bus1.issue_valid_o, 1'b1);
    chk("single_e0", bus1.issue_entry_o[0], mk(300));
    for (int k = 1; k < 4; k++) begin
      drive1(1'b1, 300 + k, 1'b1);
      #2;
      chk("single_ready", bus1.decode_ready_o, 1'b1);
      tick();
      chk("single_entry", bus1.issue_entry_o[0], mk(300 + k));
      chk("single_occ", bus1.occupancy_o, 1'd1);
    end
    drive1(1'b1, 399, 1'b0);
    #2;
    chk("single_full_ready", bus1.decode_ready_o, 1'b0);
    tick();
    drive1(1'b0, 0, 1'b1);
    tick();
    chk("single_empty_valid", bus1.issue_valid_o, 1'b0);
    chk("single_empty_occ", bus1.occupancy_o, 1'd0);
    drive1(1'b0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
